// File: rtl/usr_shift_sequencer_if.sv
// Command handshake and USR-side signals of the shift sequencer, bundled for port use.
// master = upstream command source plus the USR; slave = usr_shift_sequencer.
interface usr_shift_sequencer_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 6
);

  // Command side
  logic [DATA_WIDTH-1:0]  Word_Data_In;
  logic                   Word_Valid_In;
  logic                   Word_Ready_Out;
  logic                   Shift_Dir_In;
  logic [COUNT_WIDTH-1:0] Shift_Count_In;
  logic                   Fill_Bit_In;

  // USR control and serial taps
  logic [1:0]             USR_Mode_Out;
  logic [DATA_WIDTH-1:0]  USR_Parallel_Data_Out;
  logic                   USR_Serial_Left_Out;
  logic                   USR_Serial_Right_Out;
  logic                   USR_Serial_Right_In;
  logic                   USR_Serial_Left_In;

  // Bit stream and status
  logic                   Bit_Data_Out;
  logic                   Bit_Valid_Out;
  logic                   Frame_Done_Out;
  logic                   Busy_Out;

  modport slave (
    input  Word_Data_In,
    input  Word_Valid_In,
    output Word_Ready_Out,
    input  Shift_Dir_In,
    input  Shift_Count_In,
    input  Fill_Bit_In,
    output USR_Mode_Out,
    output USR_Parallel_Data_Out,
    output USR_Serial_Left_Out,
    output USR_Serial_Right_Out,
    input  USR_Serial_Right_In,
    input  USR_Serial_Left_In,
    output Bit_Data_Out,
    output Bit_Valid_Out,
    output Frame_Done_Out,
    output Busy_Out
  );

  modport master (
    output Word_Data_In,
    output Word_Valid_In,
    input  Word_Ready_Out,
    output Shift_Dir_In,
    output Shift_Count_In,
    output Fill_Bit_In,
    input  USR_Mode_Out,
    input  USR_Parallel_Data_Out,
    input  USR_Serial_Left_Out,
    input  USR_Serial_Right_Out,
    output USR_Serial_Right_In,
    output USR_Serial_Left_In,
    input  Bit_Data_Out,
    input  Bit_Valid_Out,
    input  Frame_Done_Out,
    input  Busy_Out
  );

endinterface

// File: rtl/usr_shift_sequencer.sv
// Frame controller for a 32-bit universal shift register: one parallel load, then N shifts,
// streaming the outgoing bits. Define USR_SEQ_ROTATE_EN to refill with the outgoing bit (rotate).
module usr_shift_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 6
) (
  input  logic                   Clk_In,
  input  logic                   Reset_In,
  usr_shift_sequencer_if.slave   bus
);

  localparam logic [1:0] MODE_LOAD      = 2'd0;
  localparam logic [1:0] MODE_SHIFT_R   = 2'd1;
  localparam logic [1:0] MODE_SHIFT_L   = 2'd2;
  localparam logic [1:0] MODE_NO_CHANGE = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   dir_q, dir_d;
  logic [COUNT_WIDTH-1:0] bits_left_q, bits_left_d;
  logic [1:0]             mode_q, mode_d;
  logic [DATA_WIDTH-1:0]  par_q, par_d;
  logic                   ser_left_q, ser_left_d;
  logic                   ser_right_q, ser_right_d;
  logic                   bit_q, bit_d;
  logic                   bit_valid_q, bit_valid_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
`ifndef USR_SEQ_ROTATE_EN
  logic                   fill_q, fill_d;
`endif

  logic [COUNT_WIDTH-1:0] eff_count_c;
  logic                   out_bit_c;

  // Zero and anything wider than the register both mean a full-width frame
  always_comb begin
    eff_count_c = bus.Shift_Count_In;
    if ((bus.Shift_Count_In == '0) || (bus.Shift_Count_In > FULL_COUNT)) begin
      eff_count_c = FULL_COUNT;
    end
  end

  // Bit leaving the USR on the next shift, from the end selected by the captured direction
  assign out_bit_c = dir_q ? bus.USR_Serial_Left_In : bus.USR_Serial_Right_In;

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      bits_left_q <= '0;
      mode_q      <= MODE_NO_CHANGE;
      par_q       <= '0;
      ser_left_q  <= 1'b0;
      ser_right_q <= 1'b0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
`ifndef USR_SEQ_ROTATE_EN
      fill_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      bits_left_q <= bits_left_d;
      mode_q      <= mode_d;
      par_q       <= par_d;
      ser_left_q  <= ser_left_d;
      ser_right_q <= ser_right_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
`ifndef USR_SEQ_ROTATE_EN
      fill_q      <= fill_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    bits_left_d = bits_left_q;
    mode_d      = mode_q;
    par_d       = par_q;
    ser_left_d  = ser_left_q;
    ser_right_d = ser_right_q;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;
`ifndef USR_SEQ_ROTATE_EN
    fill_d      = fill_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.Word_Valid_In && ready_q) begin
          dir_d       = bus.Shift_Dir_In;
          bits_left_d = eff_count_c;
          par_d       = bus.Word_Data_In;
          mode_d      = MODE_LOAD;
          state_d     = S_LOAD;
`ifdef USR_SEQ_ROTATE_EN
          ser_left_d  = 1'b0;
          ser_right_d = 1'b0;
`else
          fill_d      = bus.Fill_Bit_In;
          ser_left_d  = bus.Shift_Dir_In ? 1'b0 : bus.Fill_Bit_In;
          ser_right_d = bus.Shift_Dir_In ? bus.Fill_Bit_In : 1'b0;
`endif
        end
      end

      S_LOAD, S_SHIFT: begin
        bit_d       = out_bit_c;
        bit_valid_d = 1'b1;
        bits_left_d = bits_left_q - COUNT_WIDTH'(1);
        mode_d      = dir_q ? MODE_SHIFT_L : MODE_SHIFT_R;
`ifdef USR_SEQ_ROTATE_EN
        // USR only changes on the falling edge, so this bit is what it shifts out next
        ser_left_d  = dir_q ? 1'b0 : out_bit_c;
        ser_right_d = dir_q ? out_bit_c : 1'b0;
`endif
        state_d     = (bits_left_q == COUNT_WIDTH'(1)) ? S_DONE : S_SHIFT;
      end

      S_DONE: begin
        done_d      = 1'b1;
        mode_d      = MODE_NO_CHANGE;
        ser_left_d  = 1'b0;
        ser_right_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        mode_d  = MODE_NO_CHANGE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign bus.Word_Ready_Out        = ready_q;
  assign bus.USR_Mode_Out          = mode_q;
  assign bus.USR_Parallel_Data_Out = par_q;
  assign bus.USR_Serial_Left_Out   = ser_left_q;
  assign bus.USR_Serial_Right_Out  = ser_right_q;
  assign bus.Bit_Data_Out          = bit_q;
  assign bus.Bit_Valid_Out         = bit_valid_q;
  assign bus.Frame_Done_Out        = done_q;
  assign bus.Busy_Out              = busy_q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Randomised self-checking bench for usr_shift_sequencer with a behavioural USR attached.
module tb_usr_shift_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] usr_q = 32'h0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  usr_shift_sequencer_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  usr_shift_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .Clk_In   (clk),
    .Reset_In (rst),
    .bus      (bus)
  );

  // Universal shift register samples its controls on the falling edge
  always @(negedge clk) begin
    case (bus.USR_Mode_Out)
      2'd0:    usr_q <= bus.USR_Parallel_Data_Out;
      2'd1:    usr_q <= {bus.USR_Serial_Left_Out, usr_q[31:1]};
      2'd2:    usr_q <= {usr_q[30:0], bus.USR_Serial_Right_Out};
      default: usr_q <= usr_q;
    endcase
  end
  assign bus.USR_Serial_Right_In = usr_q[0];
  assign bus.USR_Serial_Left_In  = usr_q[31];

  function automatic int eff_n(input int cnt);
    return (cnt == 0 || cnt > 32) ? 32 : cnt;
  endfunction

  // Register contents after n shifts of word w in direction d with fill f
  function automatic logic [31:0] exp_usr(input logic [31:0] w, input logic d, input int n,
                                          input logic f);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
`ifdef USR_SEQ_ROTATE_EN
    if (!d) return (w >> n) | (w << (32 - n));
    else    return (w << n) | (w >> (32 - n));
`else
    if (n >= 32) return f ? ones : 32'h0;
    if (!d) return (w >> n) | (f ? ~(ones >> n) : 32'h0);
    else    return (w << n) | (f ? ((32'h1 << n) - 32'h1) : 32'h0);
`endif
  endfunction

  function automatic logic exp_bit(input logic [31:0] w, input logic d, input int k);
    return d ? w[31 - k] : w[k];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Word_Valid_In = 1'b0;
    tick();
    tick();
    tests++;
    if (bus.USR_Mode_Out !== 2'd3 || bus.Word_Ready_Out !== 1'b1 || bus.Bit_Valid_Out !== 1'b0 ||
        bus.Busy_Out !== 1'b0 || bus.Frame_Done_Out !== 1'b0 || bus.USR_Parallel_Data_Out !== 32'h0)
      begin
      fails++;
      $display("FAIL reset: mode=%0d ready=%b valid=%b busy=%b done=%b par=%h, want 3 1 0 0 0 0",
               bus.USR_Mode_Out, bus.Word_Ready_Out, bus.Bit_Valid_Out, bus.Busy_Out,
               bus.Frame_Done_Out, bus.USR_Parallel_Data_Out);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (bus.Word_Ready_Out !== 1'b1 || bus.Busy_Out !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%b busy=%b want 1 0", bus.Word_Ready_Out, bus.Busy_Out);
    end
  endtask

  // Issues one command and checks load, every bit, the Done pulse and final USR contents
  task automatic test_frame(input logic [31:0] w, input logic d, input int cnt, input logic f,
                            input string tag);
    int n;
    int waited;
    logic [31:0] want;
    n = eff_n(cnt);
    waited = 0;
    while (bus.Word_Ready_Out !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    tests++;
    if (bus.Word_Ready_Out !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_timeout: ready=%b want 1", tag, bus.Word_Ready_Out);
    end
    bus.Word_Data_In   = w;
    bus.Shift_Dir_In   = d;
    bus.Shift_Count_In = CW'(cnt);
    bus.Fill_Bit_In    = f;
    bus.Word_Valid_In  = 1'b1;
    tick();
    bus.Word_Valid_In  = 1'b0;
    bus.Word_Data_In   = $urandom;
    bus.Fill_Bit_In    = ~f;
    tests++;
    if (bus.USR_Mode_Out !== 2'd0 || bus.USR_Parallel_Data_Out !== w || bus.Busy_Out !== 1'b1 ||
        bus.Word_Ready_Out !== 1'b0) begin
      fails++;
      $display("FAIL %s load: mode=%0d par=%h busy=%b ready=%b want 0 %h 1 0", tag,
               bus.USR_Mode_Out, bus.USR_Parallel_Data_Out, bus.Busy_Out, bus.Word_Ready_Out, w);
    end
    for (int k = 0; k < n; k++) begin
      tick();
      tests++;
      if (bus.Bit_Valid_Out !== 1'b1 || bus.Bit_Data_Out !== exp_bit(w, d, k) ||
          bus.Frame_Done_Out !== 1'b0) begin
        fails++;
        $display("FAIL %s bit%0d: valid=%b bit=%b done=%b want 1 %b 0", tag, k,
                 bus.Bit_Valid_Out, bus.Bit_Data_Out, bus.Frame_Done_Out, exp_bit(w, d, k));
      end
    end
    tick();
    tests++;
    if (bus.Frame_Done_Out !== 1'b1 || bus.Bit_Valid_Out !== 1'b0 || bus.USR_Mode_Out !== 2'd3 ||
        bus.Word_Ready_Out !== 1'b1 || bus.Busy_Out !== 1'b0) begin
      fails++;
      $display("FAIL %s done: done=%b valid=%b mode=%0d ready=%b busy=%b want 1 0 3 1 0", tag,
               bus.Frame_Done_Out, bus.Bit_Valid_Out, bus.USR_Mode_Out, bus.Word_Ready_Out,
               bus.Busy_Out);
    end
    want = exp_usr(w, d, n, f);
    tests++;
    if (usr_q !== want) begin
      fails++;
      $display("FAIL %s usr: got %h want %h", tag, usr_q, want);
    end
    tick();
    tests++;
    if (bus.Frame_Done_Out !== 1'b0 || usr_q !== want) begin
      fails++;
      $display("FAIL %s after_done: done=%b usr=%h want 0 %h", tag, bus.Frame_Done_Out, usr_q,
               want);
    end
  endtask

  task automatic test_right_shift();
    test_frame(32'h8000_0001, 1'b0, 4, 1'b0, "right4");
  endtask

  task automatic test_left_shift();
    test_frame(32'hC000_0000, 1'b1, 2, 1'b1, "left2");
  endtask

  task automatic test_full_frames();
    test_frame(32'hA5A5_A5A5, 1'b0, 0, 1'b0, "count0_right");
    test_frame(32'h1234_5678, 1'b1, 45, 1'b1, "count45_left");
    test_frame(32'hDEAD_BEEF, 1'b0, 1, 1'b1, "count1_right");
    test_frame(32'h0F0F_0F0F, 1'b1, 32, 1'b0, "count32_left");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      test_frame($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w;
    logic [31:0] want;
    w = $urandom;
    bus.Word_Data_In   = w;
    bus.Shift_Dir_In   = 1'b0;
    bus.Shift_Count_In = CW'(10);
    bus.Fill_Bit_In    = 1'b1;
    bus.Word_Valid_In  = 1'b1;
    tick();
    bus.Word_Valid_In  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (bus.Bit_Valid_Out !== 1'b1 || bus.Bit_Data_Out !== w[k]) begin
        fails++;
        $display("FAIL midreset bit%0d: valid=%b bit=%b want 1 %b", k, bus.Bit_Valid_Out,
                 bus.Bit_Data_Out, w[k]);
      end
    end
    rst = 1'b1;
    tick();
    tests++;
    if (bus.USR_Mode_Out !== 2'd3 || bus.Bit_Valid_Out !== 1'b0 || bus.Frame_Done_Out !== 1'b0 ||
        bus.Word_Ready_Out !== 1'b1 || bus.Busy_Out !== 1'b0) begin
      fails++;
      $display("FAIL midreset state: mode=%0d valid=%b done=%b ready=%b busy=%b want 3 0 0 1 0",
               bus.USR_Mode_Out, bus.Bit_Valid_Out, bus.Frame_Done_Out, bus.Word_Ready_Out,
               bus.Busy_Out);
    end
    rst = 1'b0;
    want = exp_usr(w, 1'b0, 3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (bus.Frame_Done_Out !== 1'b0 || bus.Bit_Valid_Out !== 1'b0 || usr_q !== want) begin
        fails++;
        $display("FAIL midreset after: done=%b valid=%b usr=%h want 0 0 %h", bus.Frame_Done_Out,
                 bus.Bit_Valid_Out, usr_q, want);
      end
    end
  endtask

  // Valid held across a whole frame with a new word: accepted only once the Done pulse is out
  task automatic test_back_to_back();
    logic [31:0] wa;
    logic [31:0] wb;
    logic [31:0] want;
    int na;
    int nb;
    wa = $urandom;
    wb = $urandom;
    na = 5;
    nb = 3;
    bus.Word_Data_In   = wa;
    bus.Shift_Dir_In   = 1'b1;
    bus.Shift_Count_In = CW'(na);
    bus.Fill_Bit_In    = 1'b0;
    bus.Word_Valid_In  = 1'b1;
    tick();
    bus.Word_Data_In   = wb;
    bus.Shift_Dir_In   = 1'b0;
    bus.Shift_Count_In = CW'(nb);
    bus.Fill_Bit_In    = 1'b1;
    tests++;
    if (bus.USR_Mode_Out !== 2'd0 || bus.USR_Parallel_Data_Out !== wa) begin
      fails++;
      $display("FAIL b2b loadA: mode=%0d par=%h want 0 %h", bus.USR_Mode_Out,
               bus.USR_Parallel_Data_Out, wa);
    end
    for (int k = 0; k < na; k++) begin
      tick();
      tests++;
      if (bus.Bit_Data_Out !== wa[31 - k] || bus.Bit_Valid_Out !== 1'b1 ||
          bus.USR_Mode_Out !== 2'd2 || bus.USR_Parallel_Data_Out !== wa) begin
        fails++;
        $display("FAIL b2b bitA%0d: bit=%b valid=%b mode=%0d par=%h want %b 1 2 %h", k,
                 bus.Bit_Data_Out, bus.Bit_Valid_Out, bus.USR_Mode_Out,
                 bus.USR_Parallel_Data_Out, wa[31 - k], wa);
      end
    end
    tick();
    want = exp_usr(wa, 1'b1, na, 1'b0);
    tests++;
    if (bus.Frame_Done_Out !== 1'b1 || bus.USR_Mode_Out !== 2'd3 || usr_q !== want) begin
      fails++;
      $display("FAIL b2b doneA: done=%b mode=%0d usr=%h want 1 3 %h", bus.Frame_Done_Out,
               bus.USR_Mode_Out, usr_q, want);
    end
    tick();
    bus.Word_Valid_In = 1'b0;
    tests++;
    if (bus.USR_Mode_Out !== 2'd0 || bus.USR_Parallel_Data_Out !== wb || bus.Busy_Out !== 1'b1 ||
        bus.Frame_Done_Out !== 1'b0) begin
      fails++;
      $display("FAIL b2b acceptB: mode=%0d par=%h busy=%b done=%b want 0 %h 1 0",
               bus.USR_Mode_Out, bus.USR_Parallel_Data_Out, bus.Busy_Out, bus.Frame_Done_Out, wb);
    end
    for (int k = 0; k < nb; k++) begin
      tick();
      tests++;
      if (bus.Bit_Data_Out !== wb[k] || bus.Bit_Valid_Out !== 1'b1) begin
        fails++;
        $display("FAIL b2b bitB%0d: bit=%b valid=%b want %b 1", k, bus.Bit_Data_Out,
                 bus.Bit_Valid_Out, wb[k]);
      end
    end
    tick();
    want = exp_usr(wb, 1'b0, nb, 1'b1);
    tests++;
    if (bus.Frame_Done_Out !== 1'b1 || usr_q !== want) begin
      fails++;
      $display("FAIL b2b doneB: done=%b usr=%h want 1 %h", bus.Frame_Done_Out, usr_q, want);
    end
    tick();
  endtask

  initial begin
    bus.Word_Data_In   = '0;
    bus.Word_Valid_In  = 1'b0;
    bus.Shift_Dir_In   = 1'b0;
    bus.Shift_Count_In = '0;
    bus.Fill_Bit_In    = 1'b0;
    test_reset();
    test_right_shift();
    test_left_shift();
    test_full_frames();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

endmodule
